// File: rtl/alu_pkg.sv
// Shared ALU definitions: shifter function codes and a bit-reverse helper.
package alu_pkg;

    typedef logic [5:0] func_t;

    localparam func_t FN_SLL = 6'b000000;
    localparam func_t FN_SRL = 6'b000010;
    localparam func_t FN_SRA = 6'b000011;

    localparam int unsigned MAX_WIDTH = 64;
    localparam int unsigned IDX_W     = $clog2(MAX_WIDTH);

    // Reverses the low 'width' bits of x; bits above 'width' come back as zero.
    function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] x,
                                                         input int unsigned width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                r[IDX_W'(i)] = x[IDX_W'(width - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shifter_pipe_stage.sv
// One barrel-shifter rank: conditional left shift by 2**K with fill bit,
// followed by a holdable register carrying the whole transaction.
module shifter_stage
    import alu_pkg::*;
#(
    parameter  int unsigned WIDTH   = 32,
    parameter  int unsigned K       = 0,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_fill,
    input  func_t              in_op,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_fill,
    output func_t              out_op,
    output logic [SHAMT_W-1:0] out_shamt
);

    localparam int unsigned      AMT       = 1 << K;
    localparam logic [WIDTH-1:0] FILL_MASK = ~({WIDTH{1'b1}} << AMT);

    logic [WIDTH-1:0]   shifted;
    logic               valid_d, valid_q;
    logic [WIDTH-1:0]   data_d, data_q;
    logic               fill_d, fill_q;
    func_t              op_d, op_q;
    logic [SHAMT_W-1:0] shamt_d, shamt_q;

    always_comb begin
        shifted = in_data;
        if (in_shamt[K]) begin
            shifted = (in_data << AMT) | (in_fill ? FILL_MASK : '0);
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        fill_d  = fill_q;
        op_d    = op_q;
        shamt_d = shamt_q;
        if (en) begin
            valid_d = in_valid;
            data_d  = shifted;
            fill_d  = in_fill;
            op_d    = in_op;
            shamt_d = in_shamt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            fill_q  <= 1'b0;
            op_q    <= '0;
            shamt_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
            op_q    <= op_d;
            shamt_q <= shamt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_fill  = fill_q;
    assign out_op    = op_q;
    assign out_shamt = shamt_q;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined SLL/SRL/SRA barrel shifter with valid/ready on both sides.
// Right shifts run through the left-shift ranks on a bit-reversed operand.
module shifter_pipe
    import alu_pkg::*;
#(
    parameter  int unsigned WIDTH   = 32,
    localparam int unsigned SHAMT_W = $clog2(WIDTH),
    localparam int unsigned LATENCY = SHAMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy
);

    logic adv;

    // Index 0 is the entry register; index k+1 is the output of shift rank k.
    logic [LATENCY:0]                valid_s;
    logic [LATENCY:0][WIDTH-1:0]     data_s;
    logic [LATENCY:0]                fill_s;
    func_t [LATENCY:0]               op_s;
    logic [LATENCY:0][SHAMT_W-1:0]   shamt_s;

    logic               entry_valid_d, entry_valid_q;
    logic [WIDTH-1:0]   entry_data_d, entry_data_q;
    logic               entry_fill_d, entry_fill_q;
    func_t              entry_op_d, entry_op_q;
    logic [SHAMT_W-1:0] entry_shamt_d, entry_shamt_q;

    logic unused_bits;

    assign out_valid = valid_s[LATENCY];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && !reset;
    assign busy      = |valid_s;

    always_comb begin
        entry_valid_d = entry_valid_q;
        entry_data_d  = entry_data_q;
        entry_fill_d  = entry_fill_q;
        entry_op_d    = entry_op_q;
        entry_shamt_d = entry_shamt_q;
        if (adv) begin
            entry_valid_d = in_valid;
            entry_data_d  = dataA;
            if (Signal == FN_SRL || Signal == FN_SRA) begin
                entry_data_d = WIDTH'(bit_reverse(MAX_WIDTH'(dataA), WIDTH));
            end
            entry_fill_d  = (Signal == FN_SRA) && dataA[WIDTH-1];
            entry_op_d    = Signal;
            entry_shamt_d = dataB[SHAMT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_valid_q <= 1'b0;
            entry_data_q  <= '0;
            entry_fill_q  <= 1'b0;
            entry_op_q    <= '0;
            entry_shamt_q <= '0;
        end else begin
            entry_valid_q <= entry_valid_d;
            entry_data_q  <= entry_data_d;
            entry_fill_q  <= entry_fill_d;
            entry_op_q    <= entry_op_d;
            entry_shamt_q <= entry_shamt_d;
        end
    end

    assign valid_s[0] = entry_valid_q;
    assign data_s[0]  = entry_data_q;
    assign fill_s[0]  = entry_fill_q;
    assign op_s[0]    = entry_op_q;
    assign shamt_s[0] = entry_shamt_q;

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        shifter_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .en        (adv),
            .in_valid  (valid_s[k]),
            .in_data   (data_s[k]),
            .in_fill   (fill_s[k]),
            .in_op     (op_s[k]),
            .in_shamt  (shamt_s[k]),
            .out_valid (valid_s[k+1]),
            .out_data  (data_s[k+1]),
            .out_fill  (fill_s[k+1]),
            .out_op    (op_s[k+1]),
            .out_shamt (shamt_s[k+1])
        );
    end

    always_comb begin
        dataOut = '0;
        case (op_s[LATENCY])
            FN_SLL:         dataOut = data_s[LATENCY];
            FN_SRL, FN_SRA: dataOut = WIDTH'(bit_reverse(MAX_WIDTH'(data_s[LATENCY]), WIDTH));
            default:        dataOut = '0;
        endcase
    end

    assign unused_bits = ^{dataB[WIDTH-1:SHAMT_W], shamt_s[LATENCY], fill_s[LATENCY]};

endmodule
